msrv32_dmem_access_ctrl: RTL

Sequences data-memory load/store transactions between the pipeline's memory stage and the AHB-style data bus. Accepts one request at a time, checks alignment, drives the address and data phases, and handles wait states, error responses and a bus timeout. Stalls the pipeline while busy. Registers returned read data plus the address byte offset and size/sign controls for msrv32_load_unit, which performs byte/halfword extraction downstream.

---
 rtl/msrv32_dmem_access_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/msrv32_dmem_access_ctrl.sv
// Data-memory access sequencer: accepts one load/store from the memory stage,
// runs the AHB-style address/data phases and hands read data to the load unit.
module msrv32_dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        mem_req_valid_in,
  input  logic        mem_wr_req_in,
  input  logic [31:0] iadder_out_in,
  input  logic [31:0] rs2_data_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic        ahb_ready_in,
  input  logic        ahb_resp_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic        ms_riscv32_mp_dm_req_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic        stall_out,
  output logic [31:0] lu_data_out,
  output logic [1:0]  iadder_out_1_to_0_out,
  output logic [1:0]  load_size_out,
  output logic        load_unsigned_out,
  output logic        lu_valid_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, ERR} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             timeout_c, misaligned_c, stall_c;
  logic [3:0]       mask_c;
  logic [31:0]      sdata_c;

  logic [31:0] dmaddr_nxt, dmdata_nxt, lu_data_nxt;
  logic        dm_req_nxt, dmwr_req_nxt, lu_valid_nxt, misaligned_nxt, bus_err_nxt;
  logic        load_unsigned_nxt;
  logic [3:0]  mask_nxt;
  logic [1:0]  offset_nxt, size_nxt;

  assign cnt_inc   = cnt + CNT_W'(1);
  assign timeout_c = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  assign misaligned_c = ((load_size_in == 2'b01) && iadder_out_in[0]) ||
                        (load_size_in[1] && (iadder_out_in[1:0] != 2'b00));

  // Store lane steering: replicate data so any byte/half lane carries it
  always_comb begin
    mask_c  = 4'b1111;
    sdata_c = rs2_data_in;
    case (load_size_in)
      2'b00: begin
        mask_c  = 4'b0001 << iadder_out_in[1:0];
        sdata_c = {4{rs2_data_in[7:0]}};
      end
      2'b01: begin
        mask_c  = 4'b0011 << {iadder_out_in[1], 1'b0};
        sdata_c = {2{rs2_data_in[15:0]}};
      end
      default: begin
        mask_c  = 4'b1111;
        sdata_c = rs2_data_in;
      end
    endcase
  end

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    stall_c           = 1'b0;
    dmaddr_nxt        = ms_riscv32_mp_dmaddr_out;
    dm_req_nxt        = ms_riscv32_mp_dm_req_out;
    dmwr_req_nxt      = ms_riscv32_mp_dmwr_req_out;
    mask_nxt          = ms_riscv32_mp_dmwr_mask_out;
    dmdata_nxt        = ms_riscv32_mp_dmdata_out;
    lu_data_nxt       = lu_data_out;
    offset_nxt        = iadder_out_1_to_0_out;
    size_nxt          = load_size_out;
    load_unsigned_nxt = load_unsigned_out;
    lu_valid_nxt      = 1'b0;
    misaligned_nxt    = 1'b0;
    bus_err_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (mem_req_valid_in) begin
          if (misaligned_c) begin
            misaligned_nxt = 1'b1;
          end else begin
            stall_c           = 1'b1;
            state_nxt         = ADDR;
            cnt_nxt           = '0;
            dmaddr_nxt        = {iadder_out_in[31:2], 2'b00};
            dm_req_nxt        = 1'b1;
            dmwr_req_nxt      = mem_wr_req_in;
            mask_nxt          = mem_wr_req_in ? mask_c : 4'b0000;
            dmdata_nxt        = mem_wr_req_in ? sdata_c : 32'h0;
            offset_nxt        = iadder_out_in[1:0];
            size_nxt          = load_size_in;
            load_unsigned_nxt = load_unsigned_in;
          end
        end
      end
      ADDR: begin
        stall_c = 1'b1;
        if (ahb_ready_in) begin
          dm_req_nxt = 1'b0;
          state_nxt  = DATA;
        end else if (timeout_c) begin
          dm_req_nxt  = 1'b0;
          bus_err_nxt = 1'b1;
          state_nxt   = ERR;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      DATA: begin
        stall_c = 1'b1;
        if (ahb_ready_in) begin
          if (ahb_resp_in) begin
            bus_err_nxt = 1'b1;
            state_nxt   = ERR;
          end else begin
            if (!ms_riscv32_mp_dmwr_req_out) lu_data_nxt = ms_riscv32_mp_dmdata_in;
            lu_valid_nxt = !ms_riscv32_mp_dmwr_req_out;
            state_nxt    = DONE;
          end
        end else if (timeout_c) begin
          bus_err_nxt = 1'b1;
          state_nxt   = ERR;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall is combinational so the pipeline freezes in the accept cycle itself
  assign stall_out = ms_riscv32_mp_rst_in & stall_c;

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state                       <= IDLE;
      cnt                         <= '0;
      ms_riscv32_mp_dmaddr_out    <= 32'h0;
      ms_riscv32_mp_dm_req_out    <= 1'b0;
      ms_riscv32_mp_dmwr_req_out  <= 1'b0;
      ms_riscv32_mp_dmwr_mask_out <= 4'h0;
      ms_riscv32_mp_dmdata_out    <= 32'h0;
      lu_data_out                 <= 32'h0;
      iadder_out_1_to_0_out       <= 2'b00;
      load_size_out               <= 2'b00;
      load_unsigned_out           <= 1'b0;
      lu_valid_out                <= 1'b0;
      misaligned_out              <= 1'b0;
      bus_err_out                 <= 1'b0;
    end else begin
      state                       <= state_nxt;
      cnt                         <= cnt_nxt;
      ms_riscv32_mp_dmaddr_out    <= dmaddr_nxt;
      ms_riscv32_mp_dm_req_out    <= dm_req_nxt;
      ms_riscv32_mp_dmwr_req_out  <= dmwr_req_nxt;
      ms_riscv32_mp_dmwr_mask_out <= mask_nxt;
      ms_riscv32_mp_dmdata_out    <= dmdata_nxt;
      lu_data_out                 <= lu_data_nxt;
      iadder_out_1_to_0_out       <= offset_nxt;
      load_size_out               <= size_nxt;
      load_unsigned_out           <= load_unsigned_nxt;
      lu_valid_out                <= lu_valid_nxt;
      misaligned_out              <= misaligned_nxt;
      bus_err_out                 <= bus_err_nxt;
    end
  end

endmodule
